// File: rtl/sa_row_bfp.sv
// Block-floating-point packer for SA output rows: ping-pong row buffers,
// one shared right-shift exponent per row, int8 mantissas over valid/ready.
module sa_row_bfp #(
   parameter int ROW_LEN = 8,
   parameter int IN_W    = 64,
   parameter int OUT_W   = 8,
   parameter int EXP_W   = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   output logic [EXP_W-1:0] out_exp,
   output logic             out_last,
   output logic             ovf
);
   localparam int SW = $clog2(ROW_LEN);

   typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_t;
   typedef enum logic [1:0] {IDLE, EXP, SEND} drain_t;

   logic signed [IN_W-1:0] mem [2][ROW_LEN];
   bank_t                  bst [2];
   logic [IN_W-2:0]        acc [2];
   logic                   fb, db;
   logic [SW-1:0]          slot, beat;
   drain_t                 fsm;
   logic [EXP_W-1:0]       s;

   logic [IN_W-2:0]  term;
   logic             hs, last_hs, writable, wr, fill_done, nb, sd, sd_bank;
   logic [EXP_W-1:0] s_new;
   logic [OUT_W-1:0] first_m;
   logic [SW-1:0]    nbeat;

   // Smallest shift that brings every sample of the row into OUT_W signed bits.
   function automatic logic [EXP_W-1:0] calc_exp(input logic [IN_W-2:0] a);
      logic [EXP_W-1:0] r;
      r = '0;
      for (int i = OUT_W-1; i < IN_W-1; i++)
         if (a[i]) r = EXP_W'(i - (OUT_W-2));
      return r;
   endfunction

   function automatic logic [OUT_W-1:0] shr(input logic signed [IN_W-1:0] v,
                                            input logic [EXP_W-1:0] sh);
      logic signed [IN_W-1:0] t;
      t = v >>> sh;
      return t[OUT_W-1:0];
   endfunction

   assign term      = in_data[IN_W-2:0] ^ {(IN_W-1){in_data[IN_W-1]}};
   assign hs        = out_valid & out_ready;
   assign last_hs   = hs & out_last;
   assign nb        = ~db;
   assign writable  = (bst[fb] == B_EMPTY) || (bst[fb] == B_FILLING) ||
                      ((bst[fb] == B_DRAINING) && last_hs && (db == fb));
   assign wr        = in_valid & writable;
   assign fill_done = wr && (slot == SW'(ROW_LEN-1));
   assign nbeat     = beat + 1'b1;

   // A row starts draining from EXP, or directly off the previous row's last
   // beat when the other bank is already FULL, so back-to-back rows have no gap.
   assign sd      = (fsm == EXP) || ((fsm == SEND) && last_hs && (bst[nb] == B_FULL));
   assign sd_bank = (fsm == EXP) ? db : nb;
   assign s_new   = calc_exp(acc[sd_bank]);
   assign first_m = shr(mem[sd_bank][0], s_new);

   always_ff @(posedge clk)
      if (wr) mem[fb][slot] <= in_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            bst[b] <= B_EMPTY;
            acc[b] <= '0;
         end
         fb        <= 1'b0;
         db        <= 1'b0;
         slot      <= '0;
         beat      <= '0;
         fsm       <= IDLE;
         s         <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_exp   <= '0;
         out_last  <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         if (in_valid && !writable) ovf <= 1'b1;
         if (wr) begin
            slot <= fill_done ? '0 : slot + 1'b1;
            if (fill_done) fb <= ~fb;
         end

         // A write into a bank whose last beat drains this cycle wins.
         for (int b = 0; b < 2; b++) begin
            if (wr && fb == 1'(b)) begin
               bst[b] <= fill_done ? B_FULL : B_FILLING;
               acc[b] <= (slot == '0) ? term : (acc[b] | term);
            end else if (last_hs && db == 1'(b)) begin
               bst[b] <= B_EMPTY;
               acc[b] <= '0;
            end else if (sd && sd_bank == 1'(b)) begin
               bst[b] <= B_DRAINING;
            end
         end

         case (fsm)
            IDLE: begin
               out_valid <= 1'b0;
               if (bst[db] == B_FULL || (fill_done && fb == db)) fsm <= EXP;
            end
            EXP: begin
               s         <= s_new;
               out_exp   <= s_new;
               out_data  <= first_m;
               out_valid <= 1'b1;
               out_last  <= 1'b0;
               beat      <= '0;
               fsm       <= SEND;
            end
            SEND: begin
               if (hs && !out_last) begin
                  beat     <= nbeat;
                  out_data <= shr(mem[db][nbeat], s);
                  out_last <= (nbeat == SW'(ROW_LEN-1));
               end else if (hs) begin
                  db       <= nb;
                  beat     <= '0;
                  out_last <= 1'b0;
                  if (bst[nb] == B_FULL) begin
                     s        <= s_new;
                     out_exp  <= s_new;
                     out_data <= first_m;
                  end else begin
                     out_valid <= 1'b0;
                     fsm       <= (fill_done && fb == nb) ? EXP : IDLE;
                  end
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end
endmodule
